// File: rtl/ahb_mem_arbiter.sv
// Two-master AHB-lite arbiter sharing the single-port memory controller between
// instruction fetch (m0) and load/store (m1); fixed m1 priority with m0 anti-starvation.
module ahb_mem_arbiter #(
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic        pll_core_cpuclk,
   input  logic        pad_cpu_rst,

   input  logic        m0_hsel,
   input  logic [31:0] m0_haddr,
   input  logic [2:0]  m0_hsize,
   input  logic [1:0]  m0_htrans,
   input  logic        m0_hwrite,
   input  logic [31:0] m0_hwdata,
   output logic [31:0] m0_hrdata,
   output logic        m0_hready,
   output logic [1:0]  m0_hresp,

   input  logic        m1_hsel,
   input  logic [31:0] m1_haddr,
   input  logic [2:0]  m1_hsize,
   input  logic [1:0]  m1_htrans,
   input  logic        m1_hwrite,
   input  logic [31:0] m1_hwdata,
   output logic [31:0] m1_hrdata,
   output logic        m1_hready,
   output logic [1:0]  m1_hresp,

   output logic        arb_mem_hsel,
   output logic [31:0] arb_mem_haddr,
   output logic [2:0]  arb_mem_hsize,
   output logic [1:0]  arb_mem_htrans,
   output logic        arb_mem_hwrite,
   output logic [31:0] arb_mem_hwdata,
   input  logic [31:0] mem_arb_hrdata,
   input  logic        mem_arb_hready,
   input  logic [1:0]  mem_arb_hresp
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_PEND = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   logic [1:0]  m0_state, m1_state;
   logic [31:0] m0_hold_addr, m1_hold_addr;
   logic [2:0]  m0_hold_size, m1_hold_size;
   logic        m0_hold_write, m1_hold_write;
   logic [3:0]  starve_cnt;
   logic        owner_vld, owner_m1;
   logic [31:0] last_addr;
   logic [2:0]  last_size;
   logic        last_write;

   logic        m0_req, m1_req, m0_cand, m1_cand;
   logic        issue, pick_m0, m0_grant, m1_grant;
   logic [31:0] win_addr;
   logic [2:0]  win_size;
   logic        win_write;
   logic        unused_htrans_lsb;

   assign unused_htrans_lsb = m0_htrans[0] ^ m1_htrans[0];

   function automatic logic [1:0] next_st(input logic [1:0] st, input logic req,
                                          input logic grant, input logic slv_rdy);
      logic [1:0] nxt;
      nxt = st;
      case (st)
         ST_IDLE: if (req) nxt = grant ? ST_DATA : ST_PEND;
         ST_PEND: if (grant) nxt = ST_DATA;
         ST_DATA: if (slv_rdy) nxt = req ? (grant ? ST_DATA : ST_PEND) : ST_IDLE;
         default: nxt = ST_IDLE;
      endcase
      return nxt;
   endfunction

   assign m0_hready = (m0_state == ST_PEND) ? 1'b0 :
                      (m0_state == ST_DATA) ? mem_arb_hready : 1'b1;
   assign m1_hready = (m1_state == ST_PEND) ? 1'b0 :
                      (m1_state == ST_DATA) ? mem_arb_hready : 1'b1;

   assign m0_req  = m0_hsel & m0_htrans[1] & m0_hready;
   assign m1_req  = m1_hsel & m1_htrans[1] & m1_hready;
   assign m0_cand = (m0_state == ST_PEND) | m0_req;
   assign m1_cand = (m1_state == ST_PEND) | m1_req;

   // Issue is suppressed during reset so a held transfer can never leak out.
   assign issue    = mem_arb_hready & (m0_cand | m1_cand) & ~pad_cpu_rst;
   assign pick_m0  = m0_cand & (~m1_cand | (starve_cnt == STARVE_LIM));
   assign m0_grant = issue & pick_m0;
   assign m1_grant = issue & ~pick_m0;

   always_comb begin
      win_addr  = '0;
      win_size  = '0;
      win_write = 1'b0;
      if (pick_m0) begin
         if (m0_state == ST_PEND) begin
            win_addr  = m0_hold_addr;
            win_size  = m0_hold_size;
            win_write = m0_hold_write;
         end else begin
            win_addr  = m0_haddr;
            win_size  = m0_hsize;
            win_write = m0_hwrite;
         end
      end else if (m1_state == ST_PEND) begin
         win_addr  = m1_hold_addr;
         win_size  = m1_hold_size;
         win_write = m1_hold_write;
      end else begin
         win_addr  = m1_haddr;
         win_size  = m1_hsize;
         win_write = m1_hwrite;
      end
   end

   // Address fields fall back to the last issued request so they stay stable during a stall.
   assign arb_mem_hsel   = issue;
   assign arb_mem_htrans = issue ? 2'b10 : 2'b00;
   assign arb_mem_haddr  = issue ? win_addr  : last_addr;
   assign arb_mem_hsize  = issue ? win_size  : last_size;
   assign arb_mem_hwrite = issue ? win_write : last_write;
   assign arb_mem_hwdata = owner_vld ? (owner_m1 ? m1_hwdata : m0_hwdata) : '0;

   assign m0_hrdata = mem_arb_hrdata;
   assign m1_hrdata = mem_arb_hrdata;
   assign m0_hresp  = (owner_vld & ~owner_m1) ? mem_arb_hresp : 2'b00;
   assign m1_hresp  = (owner_vld &  owner_m1) ? mem_arb_hresp : 2'b00;

   always_ff @(posedge pll_core_cpuclk) begin
      if (pad_cpu_rst) begin
         m0_state      <= ST_IDLE;
         m1_state      <= ST_IDLE;
         m0_hold_addr  <= '0;
         m0_hold_size  <= '0;
         m0_hold_write <= 1'b0;
         m1_hold_addr  <= '0;
         m1_hold_size  <= '0;
         m1_hold_write <= 1'b0;
         starve_cnt    <= '0;
         owner_vld     <= 1'b0;
         owner_m1      <= 1'b0;
         last_addr     <= '0;
         last_size     <= '0;
         last_write    <= 1'b0;
      end else begin
         m0_state <= next_st(m0_state, m0_req, m0_grant, mem_arb_hready);
         m1_state <= next_st(m1_state, m1_req, m1_grant, mem_arb_hready);

         if (m0_req & ~m0_grant) begin
            m0_hold_addr  <= m0_haddr;
            m0_hold_size  <= m0_hsize;
            m0_hold_write <= m0_hwrite;
         end
         if (m1_req & ~m1_grant) begin
            m1_hold_addr  <= m1_haddr;
            m1_hold_size  <= m1_hsize;
            m1_hold_write <= m1_hwrite;
         end

         if (m0_grant | ~m0_cand)
            starve_cnt <= '0;
         else if (m1_grant & (starve_cnt != STARVE_LIM))
            starve_cnt <= starve_cnt + 4'd1;

         if (mem_arb_hready) begin
            owner_vld <= issue;
            owner_m1  <= m1_grant;
         end

         if (issue) begin
            last_addr  <= win_addr;
            last_size  <= win_size;
            last_write <= win_write;
         end
      end
   end

endmodule

// File: tb/tb_ahb_mem_arbiter.sv
// Directed scenarios followed by randomized two-master traffic checked against a
// per-master memory reference and a simple AHB slave model.
module tb_ahb_mem_arbiter;

   logic        pll_core_cpuclk = 1'b0;
   logic        pad_cpu_rst;
   logic        m0_hsel, m1_hsel;
   logic [31:0] m0_haddr, m1_haddr, m0_hwdata, m1_hwdata;
   logic [2:0]  m0_hsize, m1_hsize;
   logic [1:0]  m0_htrans, m1_htrans;
   logic        m0_hwrite, m1_hwrite;
   logic [31:0] m0_hrdata, m1_hrdata;
   logic        m0_hready, m1_hready;
   logic [1:0]  m0_hresp, m1_hresp;
   logic        arb_mem_hsel, arb_mem_hwrite;
   logic [31:0] arb_mem_haddr, arb_mem_hwdata;
   logic [2:0]  arb_mem_hsize;
   logic [1:0]  arb_mem_htrans;
   logic [31:0] mem_arb_hrdata;
   logic        mem_arb_hready;
   logic [1:0]  mem_arb_hresp;

   ahb_mem_arbiter #(.STARVE_MAX(4)) dut (
      .pll_core_cpuclk(pll_core_cpuclk), .pad_cpu_rst(pad_cpu_rst),
      .m0_hsel(m0_hsel), .m0_haddr(m0_haddr), .m0_hsize(m0_hsize), .m0_htrans(m0_htrans),
      .m0_hwrite(m0_hwrite), .m0_hwdata(m0_hwdata), .m0_hrdata(m0_hrdata),
      .m0_hready(m0_hready), .m0_hresp(m0_hresp),
      .m1_hsel(m1_hsel), .m1_haddr(m1_haddr), .m1_hsize(m1_hsize), .m1_htrans(m1_htrans),
      .m1_hwrite(m1_hwrite), .m1_hwdata(m1_hwdata), .m1_hrdata(m1_hrdata),
      .m1_hready(m1_hready), .m1_hresp(m1_hresp),
      .arb_mem_hsel(arb_mem_hsel), .arb_mem_haddr(arb_mem_haddr), .arb_mem_hsize(arb_mem_hsize),
      .arb_mem_htrans(arb_mem_htrans), .arb_mem_hwrite(arb_mem_hwrite),
      .arb_mem_hwdata(arb_mem_hwdata), .mem_arb_hrdata(mem_arb_hrdata),
      .mem_arb_hready(mem_arb_hready), .mem_arb_hresp(mem_arb_hresp)
   );

   always #5 pll_core_cpuclk = ~pll_core_cpuclk;

   int n_tests = 0;
   int n_fail  = 0;

   // slave model
   logic [31:0] mem [256];
   bit          dp_valid, dp_wr, dp_err, rand_mode;
   int          dp_idx, stall_force;

   // master models and reference
   logic [31:0] ref_mem [2][256];
   bit          a_act [2], a_wr [2], d_act [2], d_wr [2];
   logic [31:0] a_addr [2], a_wdata [2], d_addr [2], d_wdata [2];
   int          stall_age [2];

   function automatic logic [31:0] init_val(input int idx);
      return 32'hC0DE0000 | 32'(idx);
   endfunction

   function automatic bit is_err(input logic [31:0] a);
      return a[5:2] == 4'hF;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_tests++;
      assert (obs === want) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, want);
      end
   endtask

   task automatic slave_observe();
      if (pad_cpu_rst) begin
         dp_valid = 1'b0;
      end else if (mem_arb_hready) begin
         if (dp_valid && dp_wr && !dp_err) mem[dp_idx] = arb_mem_hwdata;
         dp_valid = arb_mem_htrans[1];
         dp_wr    = arb_mem_hwrite;
         dp_idx   = int'(arb_mem_haddr[9:2]);
         dp_err   = is_err(arb_mem_haddr);
      end
   endtask

   task automatic slave_drive();
      logic rdy;
      rdy = 1'b1;
      if (dp_valid) begin
         if (stall_force > 0) begin
            rdy = 1'b0;
            stall_force--;
         end else if (rand_mode && $urandom_range(0, 3) == 0) begin
            rdy = 1'b0;
         end
      end
      mem_arb_hready = rdy;
      mem_arb_hrdata = (dp_valid && !dp_wr) ? mem[dp_idx] : 32'h0;
      mem_arb_hresp  = (dp_valid && dp_err && rdy) ? 2'b01 : 2'b00;
   endtask

   task automatic at_neg();
      @(negedge pll_core_cpuclk);
   endtask

   task automatic adv();
      slave_observe();
      @(posedge pll_core_cpuclk);
      #1;
      slave_drive();
   endtask

   task automatic set_m0(input bit act, input logic [31:0] a, input bit wr);
      m0_hsel = act; m0_htrans = act ? 2'b10 : 2'b00; m0_haddr = a; m0_hwrite = wr; m0_hsize = 3'd2;
   endtask

   task automatic set_m1(input bit act, input logic [31:0] a, input bit wr);
      m1_hsel = act; m1_htrans = act ? 2'b10 : 2'b00; m1_haddr = a; m1_hwrite = wr; m1_hsize = 3'd2;
   endtask

   task automatic drive_masters();
      set_m0(a_act[0], a_addr[0], a_wr[0]);
      set_m1(a_act[1], a_addr[1], a_wr[1]);
      m0_hwdata = d_act[0] ? d_wdata[0] : 32'hDEAD0000;
      m1_hwdata = d_act[1] ? d_wdata[1] : 32'hDEAD0001;
   endtask

   task automatic observe_masters(output bit abort);
      logic        rdy;
      logic [1:0]  resp;
      logic [31:0] rdata;
      int          idx;
      abort = 1'b0;
      if (!mem_arb_hready) chk("no_issue_in_stall", arb_mem_htrans, 2'b00);
      for (int n = 0; n < 2; n++) begin
         rdy   = (n == 0) ? m0_hready : m1_hready;
         resp  = (n == 0) ? m0_hresp  : m1_hresp;
         rdata = (n == 0) ? m0_hrdata : m1_hrdata;
         if (rdy) begin
            stall_age[n] = 0;
            if (d_act[n]) begin
               idx = int'(d_addr[n][9:2]);
               if (is_err(d_addr[n])) begin
                  chk("rnd_err_resp", resp, 2'b01);
               end else begin
                  chk("rnd_okay_resp", resp, 2'b00);
                  if (d_wr[n]) ref_mem[n][idx] = d_wdata[n];
                  else chk("rnd_rdata", rdata, ref_mem[n][idx]);
               end
            end else begin
               chk("rnd_idle_resp", resp, 2'b00);
            end
            d_act[n]   = a_act[n];
            d_wr[n]    = a_wr[n];
            d_addr[n]  = a_addr[n];
            d_wdata[n] = a_wdata[n];
            a_act[n]   = ($urandom_range(0, 4) < 3);
            a_wr[n]    = $urandom_range(0, 1) == 1;
            a_addr[n]  = 32'(n) * 32'h200 + 32'(4 * $urandom_range(0, 15));
            a_wdata[n] = $urandom;
         end else begin
            stall_age[n]++;
            chk("rnd_stall_resp", resp, 2'b00);
            chk("rnd_stall_bound", 32'(stall_age[n] <= 64), 32'd1);
            if (stall_age[n] > 64) abort = 1'b1;
         end
      end
   endtask

   initial begin
      bit abort;
      int k;
      logic [31:0] want_addr;
      for (int i = 0; i < 256; i++) mem[i] = init_val(i);
      set_m0(1'b0, 32'h0, 1'b0);
      set_m1(1'b0, 32'h0, 1'b0);
      m0_hwdata = '0; m1_hwdata = '0;
      dp_valid = 1'b0; dp_wr = 1'b0; dp_err = 1'b0; dp_idx = 0;
      stall_force = 0; rand_mode = 1'b0;
      pad_cpu_rst = 1'b1;
      slave_drive();
      at_neg(); adv(); at_neg(); adv();
      pad_cpu_rst = 1'b0;

      // reset state
      at_neg();
      chk("rst_m0_hready", m0_hready, 1'b1);
      chk("rst_m1_hready", m1_hready, 1'b1);
      chk("rst_m0_hresp", m0_hresp, 2'b00);
      chk("rst_m1_hresp", m1_hresp, 2'b00);
      chk("rst_hsel", arb_mem_hsel, 1'b0);
      chk("rst_htrans", arb_mem_htrans, 2'b00);
      chk("rst_haddr", arb_mem_haddr, 32'h0);
      chk("rst_hwdata", arb_mem_hwdata, 32'h0);
      adv();

      // single uncontended m0 read
      set_m0(1'b1, 32'h100, 1'b0);
      at_neg();
      chk("t1_haddr", arb_mem_haddr, 32'h100);
      chk("t1_htrans", arb_mem_htrans, 2'b10);
      chk("t1_hsel", arb_mem_hsel, 1'b1);
      chk("t1_m0_hready_a", m0_hready, 1'b1);
      adv();
      set_m0(1'b0, 32'h0, 1'b0);
      at_neg();
      chk("t1_m0_hready_d", m0_hready, 1'b1);
      chk("t1_m0_hrdata", m0_hrdata, init_val(32'h40));
      adv();

      // simultaneous: m1 write wins, m0 read held one cycle
      set_m0(1'b1, 32'h200, 1'b0);
      set_m1(1'b1, 32'h300, 1'b1);
      at_neg();
      chk("t2_haddr_m1", arb_mem_haddr, 32'h300);
      chk("t2_hwrite_m1", arb_mem_hwrite, 1'b1);
      chk("t2_m0_hready_a", m0_hready, 1'b1);
      adv();
      set_m0(1'b0, 32'h0, 1'b0);
      set_m1(1'b0, 32'h0, 1'b0);
      m1_hwdata = 32'hA5A5A5A5;
      at_neg();
      chk("t2_m0_hready_pend", m0_hready, 1'b0);
      chk("t2_haddr_m0", arb_mem_haddr, 32'h200);
      chk("t2_htrans_m0", arb_mem_htrans, 2'b10);
      chk("t2_hwrite_m0", arb_mem_hwrite, 1'b0);
      chk("t2_hwdata", arb_mem_hwdata, 32'hA5A5A5A5);
      adv();
      at_neg();
      chk("t2_m0_hready_d", m0_hready, 1'b1);
      chk("t2_m0_hrdata", m0_hrdata, init_val(32'h80));
      adv();
      set_m1(1'b1, 32'h300, 1'b0);
      at_neg();
      chk("t2_rd_haddr", arb_mem_haddr, 32'h300);
      adv();
      set_m1(1'b0, 32'h0, 1'b0);
      at_neg();
      chk("t2_rd_back", m1_hrdata, 32'hA5A5A5A5);
      adv();

      // starvation limit: m0 wins after 4 consecutive m1 grants
      k = 0;
      for (int c = 0; c < 6; c++) begin
         set_m1(1'b1, 32'h300 + 32'(4 * k), 1'b0);
         set_m0(c == 0, 32'h104, 1'b0);
         at_neg();
         want_addr = (c < 4) ? 32'h300 + 32'(4 * c) : (c == 4) ? 32'h104 : 32'h310;
         chk("t3_haddr", arb_mem_haddr, want_addr);
         chk("t3_m0_hready", m0_hready, (c == 0 || c == 5) ? 1'b1 : 1'b0);
         if (c == 5) chk("t3_m0_hrdata", m0_hrdata, init_val(32'h41));
         if (m1_hready) k++;
         adv();
      end
      set_m1(1'b0, 32'h0, 1'b0);
      at_neg();
      chk("t3_starve_clr", 32'(dut.starve_cnt), 32'd0);
      adv();
      at_neg(); adv();

      // slave stall: m0 captured, address held, m0 issued when slave frees
      set_m1(1'b1, 32'h304, 1'b0);
      at_neg();
      chk("t4_haddr_m1", arb_mem_haddr, 32'h304);
      stall_force = 2;
      adv();
      set_m1(1'b0, 32'h0, 1'b0);
      set_m0(1'b1, 32'h108, 1'b0);
      at_neg();
      chk("t4_htrans_s1", arb_mem_htrans, 2'b00);
      chk("t4_haddr_s1", arb_mem_haddr, 32'h304);
      chk("t4_m0_hready_s1", m0_hready, 1'b1);
      chk("t4_m1_hready_s1", m1_hready, 1'b0);
      adv();
      set_m0(1'b0, 32'h0, 1'b0);
      at_neg();
      chk("t4_htrans_s2", arb_mem_htrans, 2'b00);
      chk("t4_haddr_s2", arb_mem_haddr, 32'h304);
      chk("t4_m0_hready_s2", m0_hready, 1'b0);
      adv();
      at_neg();
      chk("t4_htrans_go", arb_mem_htrans, 2'b10);
      chk("t4_haddr_m0", arb_mem_haddr, 32'h108);
      chk("t4_m1_hrdata", m1_hrdata, init_val(32'hC1));
      adv();
      at_neg();
      chk("t4_m0_hready_d", m0_hready, 1'b1);
      chk("t4_m0_hrdata", m0_hrdata, init_val(32'h42));
      adv();

      // reset while m0 is held
      set_m1(1'b1, 32'h308, 1'b0);
      set_m0(1'b1, 32'h10C, 1'b0);
      at_neg();
      chk("t5_haddr_m1", arb_mem_haddr, 32'h308);
      adv();
      set_m0(1'b0, 32'h0, 1'b0);
      set_m1(1'b0, 32'h0, 1'b0);
      pad_cpu_rst = 1'b1;
      at_neg();
      chk("t5_htrans_in_rst", arb_mem_htrans, 2'b00);
      adv();
      pad_cpu_rst = 1'b0;
      at_neg();
      chk("t5_m0_hready", m0_hready, 1'b1);
      chk("t5_htrans", arb_mem_htrans, 2'b00);
      chk("t5_hsel", arb_mem_hsel, 1'b0);
      adv();
      at_neg();
      chk("t5_no_stale", arb_mem_htrans, 2'b00);
      chk("t5_m0_hready2", m0_hready, 1'b1);
      adv();

      // randomized traffic, disjoint regions per master
      for (int i = 0; i < 256; i++) begin
         mem[i] = init_val(i);
         ref_mem[0][i] = init_val(i);
         ref_mem[1][i] = init_val(i);
      end
      for (int n = 0; n < 2; n++) begin
         a_act[n] = 1'b0; d_act[n] = 1'b0; a_wr[n] = 1'b0; d_wr[n] = 1'b0;
         a_addr[n] = '0; d_addr[n] = '0; a_wdata[n] = '0; d_wdata[n] = '0;
         stall_age[n] = 0;
      end
      rand_mode = 1'b1;
      abort = 1'b0;
      for (int c = 0; c < 3000 && !abort; c++) begin
         drive_masters();
         at_neg();
         observe_masters(abort);
         adv();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
